// File: rtl/down_counter_timer.sv
// ---------------------------------------------------------------------------
// down_counter_timer
//
// Loadable synchronous down-counter/timer. A count is loaded, started, and
// then decremented on every clock edge where T=1 until it reaches zero. The
// edge that takes the count from 1 to 0 is the terminal edge. In the cycle
// after a terminal edge, done is high for exactly one clock.
//
// Optional feature (compile-time macro DOWNCNT_AUTORELOAD_EN):
//   defined   - On the terminal edge the count reloads from the value last
//               loaded, and the timer keeps running. It stops only on stop,
//               load or reset. A reload value of zero drops the timer back
//               to IDLE, so it cannot sit in a zero-length run.
//   undefined - There is no reload register. The terminal edge always
//               returns the timer to IDLE with out=0.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-low reset
//   load      in   1      out <= load_val, abort any run (highest after reset)
//   load_val  in   WIDTH  value captured on load
//   start     in   1      begin counting from the current out (IDLE only)
//   stop      in   1      halt a run; out holds
//   T         in   1      count enable
//   out       out  WIDTH  current count
//   busy      out  1      high while running
//   done      out  1      one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             T,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;

`ifdef DOWNCNT_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef DOWNCNT_AUTORELOAD_EN
    reload_d = reload_q;
`endif

    if (load) begin
      // A load aborts everything, including a coincident terminal edge.
      out_d   = load_val;
      state_d = ST_IDLE;
`ifdef DOWNCNT_AUTORELOAD_EN
      reload_d = load_val;
`endif
    end else if (stop) begin
      // A stop also masks a start in the same cycle. In IDLE it changes nothing.
      state_d = ST_IDLE;
    end else if (start && (state_q == ST_IDLE)) begin
      if (out_q == CNT_ZERO) begin
        // A zero-length timer fires immediately and never enters RUN.
        done_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if ((state_q == ST_RUN) && T) begin
      // A start while in RUN lands here and is ignored; counting continues.
      if (out_q > CNT_ONE) begin
        out_d = out_q - CNT_ONE;
      end else begin
        // Terminal edge. Also treat a zero count as terminal, so the counter
        // can never wrap below zero.
        done_d = 1'b1;
`ifdef DOWNCNT_AUTORELOAD_EN
        if (reload_q != CNT_ZERO) begin
          out_d   = reload_q;
          state_d = ST_RUN;
        end else begin
          out_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end
`else
        out_d   = CNT_ZERO;
        state_d = ST_IDLE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      out_q   <= CNT_ZERO;
      done_q  <= 1'b0;
`ifdef DOWNCNT_AUTORELOAD_EN
      reload_q <= CNT_ZERO;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef DOWNCNT_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// ---------------------------------------------------------------------------
// tb_down_counter_timer
//
// Directed bench for down_counter_timer (WIDTH=8).
//
// A behavioural model tracks the remaining count, a running flag and the
// reload value as plain integers. The model is updated from the inputs at
// every rising edge. On every falling edge, the DUT outputs are compared
// against the model. Literal expectations written by hand at key points pin
// both the DUT and the model.
//
// Build with DOWNCNT_AUTORELOAD_EN defined to exercise the reload variant.
// ---------------------------------------------------------------------------
module tb_down_counter_timer;

`ifdef DOWNCNT_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       stop;
  logic       T;
  logic [7:0] out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  down_counter_timer #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .T        (T),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_out  = 0;
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  int m_rel  = 0;

  always @(posedge clk) begin : model
    int n_out;
    int n_rel;
    bit n_run;
    bit n_done;
    n_out  = m_out;
    n_rel  = m_rel;
    n_run  = m_run;
    n_done = 1'b0;
    if (reset !== 1'b1) begin
      n_out = 0;
      n_rel = 0;
      n_run = 1'b0;
    end else if (load) begin
      n_out = int'(load_val);
      n_rel = int'(load_val);
      n_run = 1'b0;
    end else if (stop) begin
      n_run = 1'b0;
    end else if (start && !m_run) begin
      // Starting at zero is a zero-length timer: it pulses and stays idle.
      if (m_out == 0) n_done = 1'b1;
      else            n_run  = 1'b1;
    end else if (m_run && T) begin
      if (m_out > 1) begin
        n_out = m_out - 1;
      end else begin
        n_done = 1'b1;
        if (AUTO && m_rel != 0) begin
          n_out = m_rel;
        end else begin
          n_out = 0;
          n_run = 1'b0;
        end
      end
    end
    m_out  <= n_out;
    m_rel  <= n_rel;
    m_run  <= n_run;
    m_done <= n_done;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      n_checks = n_checks + 1;
      if (out !== m_out[7:0] || busy !== m_run || done !== m_done) begin
        n_fail = n_fail + 1;
        $display("FAIL cycle_cmp t=%0t: got out=%0d busy=%0b done=%0b, want out=%0d busy=%0b done=%0b",
                 $time, out, busy, done, m_out, m_run, m_done);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("[tb] %s: got %0d ok", name, act);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    tick;
    load     = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic do_stop;
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    bit seen;
    reset = 1'b0; load = 1'b0; load_val = 8'h00;
    start = 1'b0; stop = 1'b0; T = 1'b0;

    tick;
    cmp_en = 1'b1;
    tick;
    check("reset_out",  32'(out),  0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    reset = 1'b1;

    // Reset during a run with out=0x37
    do_load(8'h38);
    do_start;
    T = 1'b1;
    tick;
    check("midrun_out",  32'(out),  32'h37);
    check("midrun_busy", 32'(busy), 1);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    T = 1'b0;
    check("rst_mid_out",  32'(out),  0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);

    // One-shot from 5
    do_load(8'd5);
    check("os_load_out",  32'(out),  5);
    check("os_load_busy", 32'(busy), 0);
    do_start;
    check("os_start_busy", 32'(busy), 1);
    check("os_start_out",  32'(out),  5);
    T = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      tick;
      check($sformatf("os_out_%0d", k), 32'(out), 32'(k));
      check($sformatf("os_done_%0d", k), 32'(done), 0);
    end
    tick;
    check("os_term_done",  32'(done),  1);
    check("os_term_out",   32'(out),   AUTO ? 5 : 0);
    check("os_term_busy",  32'(busy),  32'(AUTO));
    check("os_model_out",  32'(m_out), AUTO ? 5 : 0);
    check("os_model_done", 32'(m_done), 1);
    T = 1'b0;
    do_stop;
    check("os_after_done", 32'(done), 0);
    check("os_after_busy", 32'(busy), 0);

    // Pause and stop
    do_load(8'd4);
    do_start;
    check("ps_busy", 32'(busy), 1);
    T = 1'b1; tick; check("ps_out_a", 32'(out), 3);
    T = 1'b0; tick; check("ps_out_b", 32'(out), 3);
    tick;           check("ps_out_c", 32'(out), 3);
    check("ps_pause_busy", 32'(busy), 1);
    T = 1'b1; tick; check("ps_out_d", 32'(out), 2);
    T = 1'b0;
    do_stop;
    check("ps_stop_out",  32'(out),  2);
    check("ps_stop_busy", 32'(busy), 0);
    tick;
    check("ps_hold_out", 32'(out), 2);
    do_start;
    check("ps_resume_busy", 32'(busy), 1);
    T = 1'b1; tick;
    check("ps_res_out1",  32'(out),  1);
    check("ps_res_done1", 32'(done), 0);
    tick;
    check("ps_res_done2", 32'(done), 1);
    check("ps_res_out2",  32'(out),  AUTO ? 4 : 0);
    T = 1'b0;
    do_stop;

    // Zero-length start, then abort by load
    do_load(8'd0);
    do_start;
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    tick;
    check("zero_done_clr", 32'(done), 0);
    do_load(8'd9);
    do_start;
    T = 1'b1;
    tick; tick; tick;
    check("abort_pre_out", 32'(out), 6);
    do_load(8'd3);
    check("abort_out",  32'(out),  3);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    tick;
    check("abort_done2", 32'(done), 0);
    T = 1'b0;

    // Load coinciding with the terminal edge: the load wins
    do_load(8'd2);
    do_start;
    T = 1'b1;
    tick;
    check("coll_pre_out", 32'(out), 1);
    do_load(8'd7);
    check("coll_out",  32'(out),  7);
    check("coll_done", 32'(done), 0);
    check("coll_busy", 32'(busy), 0);
    T = 1'b0;

    // 0xFF boundary, with an ignored start mid-run
    do_load(8'hFF);
    do_start;
    T = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      if (i == 100) start = 1'b1;
      tick;
      start = 1'b0;
      n = n + 1;
      if (i == 100) begin
        check("ff_midstart_out",  32'(out),  155);
        check("ff_midstart_busy", 32'(busy), 1);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("ff_done_seen",  32'(seen), 1);
    check("ff_edge_count", 32'(n),    255);
    T = 1'b0;
    do_stop;

`ifdef DOWNCNT_AUTORELOAD_EN
    // Periodic reload
    do_load(8'd3);
    do_start;
    T = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      check($sformatf("ar_out_%0d", k),  32'(out),  32'(3 - (k % 3)));
      check($sformatf("ar_done_%0d", k), 32'(done), (k % 3 == 0) ? 1 : 0);
    end
    T = 1'b0;
    do_stop;
    check("ar_stop_busy", 32'(busy), 0);
    T = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      check($sformatf("ar_quiet_%0d", k), 32'(done), 0);
    end
    T = 1'b0;
`endif

    tick;
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
